approx_mult_error_monitor: RTL and testbench

//  Downstream consumer of the unsigned 8x8 approximate multipliers: samples (x, y, z_approx) triples.

---
 rtl/pam_err_pkg.sv | 20 ++
 rtl/approx_mult_error_monitor_if.sv | 32 +++
 rtl/err_dist_unit.sv | 16 +
 rtl/approx_mult_error_monitor.sv | 143 ++++++++++++++
 tb/tb_approx_mult_error_monitor.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pam_err_pkg.sv
// Shared widths, FSM state and sample record for the approximate-multiplier error monitor.
package pam_err_pkg;

  localparam int W      = 8;
  localparam int PROD_W = 2 * W;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [PROD_W-1:0] exact;
    logic [PROD_W-1:0] approx;
  } err_sample_t;

endpackage

// File: rtl/approx_mult_error_monitor_if.sv
// Sample-stream and result bus of the error monitor; master = sample producer, slave = monitor.
interface approx_mult_error_monitor_if #(
  parameter int W     = pam_err_pkg::W,
  parameter int CNT_W = pam_err_pkg::CNT_W,
  parameter int ACC_W = pam_err_pkg::ACC_W
);

  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       x;
  logic [W-1:0]       y;
  logic [2*W-1:0]     z_approx;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   err_sum;
  logic [2*W-1:0]     err_max;
  logic [CNT_W-1:0]   err_count;
  logic [2*ACC_W-1:0] sq_sum;

  modport master (
    output start, num_samples, in_valid, x, y, z_approx,
    input  in_ready, busy, done, err_sum, err_max, err_count, sq_sum
  );

  modport slave (
    input  start, num_samples, in_valid, x, y, z_approx,
    output in_ready, busy, done, err_sum, err_max, err_count, sq_sum
  );

endinterface

// File: rtl/err_dist_unit.sv
// Combinational error distance |a-b| with a nonzero flag.
module err_dist_unit #(
  parameter int PROD_W = pam_err_pkg::PROD_W
) (
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] ed,
  output logic              nz
);

  always_comb begin
    ed = (a >= b) ? (a - b) : (b - a);
    nz = (a != b);
  end

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Windowed error-metric monitor for unsigned WxW approximate multipliers.
// Optional ERR_SQ_EN macro adds a saturating sum of squared error distances.
module approx_mult_error_monitor #(
  parameter int W     = pam_err_pkg::W,
  parameter int CNT_W = pam_err_pkg::CNT_W,
  parameter int ACC_W = pam_err_pkg::ACC_W
) (
  input logic clk,
  input logic rst_n,
  approx_mult_error_monitor_if.slave bus
);

  import pam_err_pkg::*;

  localparam int PROD_W = 2 * W;

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   num_lat;
  logic [CNT_W-1:0]   accepted;
  logic [CNT_W-1:0]   retired;
  logic               start_ok;
  logic               xfer;
  logic               vld_p1;
  logic [PROD_W-1:0]  exact_p1;
  logic [PROD_W-1:0]  approx_p1;
  logic [PROD_W-1:0]  ed_p1;
  logic               ed_nz_p1;
  logic [ACC_W-1:0]   err_sum;
  logic [PROD_W-1:0]  err_max;
  logic [CNT_W-1:0]   err_count;

  function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] acc,
                                                    input logic [PROD_W-1:0] inc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(inc);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign start_ok      = bus.start && ((state == IDLE) || (state == DONE));
  assign bus.in_ready  = (state == RUN) && (accepted < num_lat);
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign xfer          = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (num_lat == '0)
          state_nxt = DONE;
        else if (vld_p1 && (retired == num_lat - CNT_W'(1)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      num_lat  <= '0;
      accepted <= '0;
      retired  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= xfer;
      if (start_ok) begin
        num_lat  <= bus.num_samples;
        accepted <= '0;
        retired  <= '0;
      end else begin
        if (xfer)   accepted <= accepted + CNT_W'(1);
        if (vld_p1) retired  <= retired + CNT_W'(1);
      end
    end
  end

  // ---- stage 1: exact product and approximate result registered on transfer
  always_ff @(posedge clk) begin
    if (xfer) begin
      exact_p1  <= PROD_W'(bus.x) * PROD_W'(bus.y);
      approx_p1 <= bus.z_approx;
    end
  end

  // ---- stage 2: error distance and accumulator update
  err_dist_unit #(.PROD_W(PROD_W)) u_err_dist (
    .a  (exact_p1),
    .b  (approx_p1),
    .ed (ed_p1),
    .nz (ed_nz_p1)
  );

  // start and vld_p1 are exclusive: start is only honoured outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum   <= '0;
      err_max   <= '0;
      err_count <= '0;
    end else if (start_ok) begin
      err_sum   <= '0;
      err_max   <= '0;
      err_count <= '0;
    end else if (vld_p1) begin
      err_sum   <= sat_add_acc(err_sum, ed_p1);
      err_max   <= (ed_p1 > err_max) ? ed_p1 : err_max;
      err_count <= err_count + CNT_W'(ed_nz_p1);
    end
  end

  assign bus.err_sum   = err_sum;
  assign bus.err_max   = err_max;
  assign bus.err_count = err_count;

`ifdef ERR_SQ_EN
  logic [4*W-1:0]     sq_p1;
  logic [2*ACC_W-1:0] sq_sum;

  function automatic logic [2*ACC_W-1:0] sat_add_sq(input logic [2*ACC_W-1:0] acc,
                                                     input logic [4*W-1:0]     inc);
    logic [2*ACC_W:0] s;
    s = {1'b0, acc} + (2*ACC_W+1)'(inc);
    return s[2*ACC_W] ? '1 : s[2*ACC_W-1:0];
  endfunction

  assign sq_p1 = (4*W)'(ed_p1) * (4*W)'(ed_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sq_sum <= '0;
    else if (start_ok) sq_sum <= '0;
    else if (vld_p1)   sq_sum <= sat_add_sq(sq_sum, sq_p1);
  end

  assign bus.sq_sum = sq_sum;
`else
  assign bus.sq_sum = '0;
`endif

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench: a default-width monitor and an ACC_W=17 monitor share one sample stream.
module tb_approx_mult_error_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 40;
  localparam int ACC_S = 17;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic [2*W-1:0] z_approx = '0;

  always #5 clk = ~clk;

  approx_mult_error_monitor_if #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus_a ();
  approx_mult_error_monitor_if #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) bus_b ();

  assign bus_a.start = start;       assign bus_b.start = start;
  assign bus_a.num_samples = num_samples; assign bus_b.num_samples = num_samples;
  assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
  assign bus_a.x = x;               assign bus_b.x = x;
  assign bus_a.y = y;               assign bus_b.y = y;
  assign bus_a.z_approx = z_approx; assign bus_b.z_approx = z_approx;

  approx_mult_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  approx_mult_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0]   xs [8];
  logic [W-1:0]   ys [8];
  logic [2*W-1:0] zs [8];

`ifdef ERR_SQ_EN
  localparam logic [2*ACC_W-1:0] SQ_ONE   = 80'd4228250625;
  localparam logic [2*ACC_W-1:0] SQ_THREE = 80'd12684751875;
  localparam logic [2*ACC_S-1:0] SQ_THREE_S = 34'd12684751875;
`else
  localparam logic [2*ACC_W-1:0] SQ_ONE   = '0;
  localparam logic [2*ACC_W-1:0] SQ_THREE = '0;
  localparam logic [2*ACC_S-1:0] SQ_THREE_S = '0;
`endif

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int n, input bit gap, input bit hold_valid,
                            output int latency, output int transfers, output logic ready_after);
    int  cycles;
    bit  take;
    cycles = 0;
    start = 1'b1;
    num_samples = CNT_W'(n);
    cyc;
    start = 1'b0;
    transfers = 0;
    latency = -1;
    while (transfers < n && cycles < 200) begin
      in_valid = !(gap && cycles[0]);
      x = xs[transfers];
      y = ys[transfers];
      z_approx = zs[transfers];
      take = in_valid && bus_a.in_ready;
      cyc;
      if (take) transfers++;
      cycles++;
    end
    ready_after = bus_a.in_ready;
    in_valid = hold_valid;
    x = 8'd255; y = 8'd255; z_approx = 16'd0;
    for (int k = 0; k < 10; k++) begin
      if (bus_a.done) begin
        latency = k;
        break;
      end
      cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    cyc; cyc;
    tests_run++;
    if ({bus_a.busy, bus_a.done, bus_a.in_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b expected 000", {bus_a.busy, bus_a.done, bus_a.in_ready});
    end
    tests_run++;
    if (bus_a.err_sum !== '0 || bus_a.err_max !== '0 || bus_a.err_count !== '0 || bus_a.sq_sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_results got sum=%0d max=%0d cnt=%0d sq=%0d expected all 0",
               bus_a.err_sum, bus_a.err_max, bus_a.err_count, bus_a.sq_sum);
    end
    rst_n = 1'b1;
    cyc;
  endtask

  task automatic test_exact_match;
    int lat, nx;
    logic rdy;
    xs[0] = 8'd3;   ys[0] = 8'd4;   zs[0] = 16'd12;
    xs[1] = 8'd17;  ys[1] = 8'd9;   zs[1] = 16'd153;
    xs[2] = 8'd255; ys[2] = 8'd1;   zs[2] = 16'd255;
    xs[3] = 8'd0;   ys[3] = 8'd200; zs[3] = 16'd0;
    run_window(4, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (lat !== 1 || nx !== 4) begin
      tests_failed++;
      $display("FAIL exact_latency got lat=%0d xfers=%0d expected lat=1 xfers=4", lat, nx);
    end
    tests_run++;
    if (bus_a.err_sum !== '0 || bus_a.err_max !== '0 || bus_a.err_count !== '0) begin
      tests_failed++;
      $display("FAIL exact_results got sum=%0d max=%0d cnt=%0d expected 0 0 0",
               bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    tests_run++;
    if (bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL exact_busy_at_done got %b expected 0", bus_a.busy);
    end
    cyc;
  endtask

  task automatic test_single_max;
    int lat, nx;
    logic rdy;
    xs[0] = 8'd255; ys[0] = 8'd255; zs[0] = 16'd0;
    run_window(1, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (lat !== 1 || bus_a.err_sum !== 40'd65025 || bus_a.err_max !== 16'd65025 || bus_a.err_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_max got lat=%0d sum=%0d max=%0d cnt=%0d expected 1 65025 65025 1",
               lat, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    tests_run++;
    if (bus_a.sq_sum !== SQ_ONE) begin
      tests_failed++;
      $display("FAIL single_sq got %0d expected %0d", bus_a.sq_sum, SQ_ONE);
    end
    cyc;
  endtask

  task automatic test_mixed;
    int lat, nx;
    logic rdy;
    xs[0] = 8'd3;   ys[0] = 8'd5;  zs[0] = 16'd14;
    xs[1] = 8'd10;  ys[1] = 8'd10; zs[1] = 16'd100;
    xs[2] = 8'd200; ys[2] = 8'd2;  zs[2] = 16'd410;
    run_window(3, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (lat !== 1 || bus_a.err_sum !== 40'd11 || bus_a.err_max !== 16'd10 || bus_a.err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL mixed got lat=%0d sum=%0d max=%0d cnt=%0d expected 1 11 10 2",
               lat, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    cyc;
    tests_run++;
    if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.err_sum !== 40'd11 || bus_a.err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL mixed_hold got done=%b busy=%b sum=%0d cnt=%0d expected 0 0 11 2",
               bus_a.done, bus_a.busy, bus_a.err_sum, bus_a.err_count);
    end
  endtask

  task automatic test_zero_and_gapped;
    int lat, nx;
    logic rdy;
    run_window(0, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (lat !== 1 || nx !== 0 || bus_a.err_sum !== '0 || bus_a.err_max !== '0 || bus_a.err_count !== '0) begin
      tests_failed++;
      $display("FAIL zero_window got lat=%0d xfers=%0d sum=%0d max=%0d cnt=%0d expected 1 0 0 0 0",
               lat, nx, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    cyc;
    xs[0] = 8'd1; ys[0] = 8'd1; zs[0] = 16'd1;
    xs[1] = 8'd2; ys[1] = 8'd3; zs[1] = 16'd7;
    xs[2] = 8'd4; ys[2] = 8'd4; zs[2] = 16'd0;
    run_window(3, 1'b1, 1'b1, lat, nx, rdy);
    tests_run++;
    if (nx !== 3 || rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL gapped_xfers got xfers=%0d in_ready=%b expected 3 0", nx, rdy);
    end
    tests_run++;
    if (lat !== 1 || bus_a.err_sum !== 40'd17 || bus_a.err_max !== 16'd16 || bus_a.err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL gapped_results got lat=%0d sum=%0d max=%0d cnt=%0d expected 1 17 16 2",
               lat, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    cyc;
  endtask

  task automatic test_saturation;
    int lat, nx;
    logic rdy;
    for (int i = 0; i < 3; i++) begin
      xs[i] = 8'd255; ys[i] = 8'd255; zs[i] = 16'd0;
    end
    run_window(3, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (bus_b.err_sum !== 17'd131071 || bus_b.err_max !== 16'd65025 || bus_b.err_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL sat_narrow got sum=%0d max=%0d cnt=%0d expected 131071 65025 3",
               bus_b.err_sum, bus_b.err_max, bus_b.err_count);
    end
    tests_run++;
    if (bus_a.err_sum !== 40'd195075 || lat !== 1) begin
      tests_failed++;
      $display("FAIL sat_wide got sum=%0d lat=%0d expected 195075 1", bus_a.err_sum, lat);
    end
    tests_run++;
    if (bus_a.sq_sum !== SQ_THREE || bus_b.sq_sum !== SQ_THREE_S) begin
      tests_failed++;
      $display("FAIL sat_sq got wide=%0d narrow=%0d expected %0d %0d",
               bus_a.sq_sum, bus_b.sq_sum, SQ_THREE, SQ_THREE_S);
    end
    cyc;
  endtask

  task automatic test_reset_mid_window;
    int lat, nx;
    logic rdy;
    start = 1'b1; num_samples = 16'd4;
    cyc;
    start = 1'b0;
    in_valid = 1'b1; x = 8'd10; y = 8'd10; z_approx = 16'd0;
    cyc;
    x = 8'd5; y = 8'd5; z_approx = 16'd0;
    cyc;
    tests_run++;
    if (bus_a.err_sum !== 40'd100 || bus_a.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_before_reset got sum=%0d busy=%b expected 100 1", bus_a.err_sum, bus_a.busy);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus_a.busy, bus_a.done, bus_a.in_ready} !== 3'b000 || bus_a.err_sum !== '0 ||
        bus_a.err_max !== '0 || bus_a.err_count !== '0 || bus_a.sq_sum !== '0) begin
      tests_failed++;
      $display("FAIL mid_async_reset got ctrl=%b sum=%0d max=%0d cnt=%0d expected 000 0 0 0",
               {bus_a.busy, bus_a.done, bus_a.in_ready}, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    cyc; cyc;
    rst_n = 1'b1;
    cyc;
    xs[0] = 8'd7; ys[0] = 8'd7; zs[0] = 16'd40;
    run_window(1, 1'b0, 1'b0, lat, nx, rdy);
    tests_run++;
    if (lat !== 1 || bus_a.err_sum !== 40'd9 || bus_a.err_max !== 16'd9 || bus_a.err_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL restart got lat=%0d sum=%0d max=%0d cnt=%0d expected 1 9 9 1",
               lat, bus_a.err_sum, bus_a.err_max, bus_a.err_count);
    end
    cyc;
  endtask

  initial begin
    test_reset;
    test_exact_match;
    test_single_max;
    test_mixed;
    test_zero_and_gapped;
    test_saturation;
    test_reset_mid_window;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
